// File: rtl/func_seq_pkg.sv
// Shared encodings for the shift/rotate sequencer and its function-unit interface.
package func_seq_pkg;

    localparam int unsigned OP_W      = 2;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned FS_W      = 6;
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned MAX_STEPS = 16;

    typedef enum logic [OP_W-1:0] {
        OP_RRA = 2'b00,
        OP_RRC = 2'b01,
        OP_RLA = 2'b10,
        OP_RLC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Function-unit decode: NOP passes A straight through.
    localparam logic [FS_W-1:0] FS_NOP  = 6'h00;
    localparam logic [FS_W-1:0] FS_ADD  = 6'h01;
    localparam logic [FS_W-1:0] FS_ADDC = 6'h02;
    localparam logic [FS_W-1:0] FS_RRA  = 6'h10;
    localparam logic [FS_W-1:0] FS_RRC  = 6'h11;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : cnt;
    endfunction

endpackage

// File: rtl/func_seq.sv
// Multi-step shift/rotate sequencer driving the shared function unit.
// Optional abort input enabled by defining FUNC_SEQ_ABORT_EN.
module func_seq
    import func_seq_pkg::*;
#(
    parameter int unsigned SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              bw,
    input  logic [SIZE-1:0]   operand,
    input  logic              c_in,
`ifdef FUNC_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   result,
    output logic [FLAG_W-1:0] cvnz,
    output logic [SIZE-1:0]   fu_A,
    output logic [SIZE-1:0]   fu_B,
    output logic [FS_W-1:0]   fu_FS,
    output logic              fu_Cin,
    output logic              fu_BW,
    input  logic [SIZE-1:0]   fu_F,
    input  logic [FLAG_W-1:0] fu_CVNZ
);

    state_e             state_q;
    state_e             state_d;
    logic [SIZE-1:0]    acc_q;
    logic               carry_q;
    op_e                op_q;
    logic               bw_q;
    logic [CNT_W-1:0]   steps_q;
    logic               last_step;
    logic               abort_hit;
    logic               zero_msb;

`ifdef FUNC_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_step = (steps_q == CNT_W'(1));
    assign zero_msb  = bw ? operand[SIZE/2-1] : operand[SIZE-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks the final-step transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode and function-unit drive.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        fu_FS  = FS_NOP;
        fu_A   = acc_q;
        fu_B   = acc_q;
        fu_Cin = 1'b0;
        fu_BW  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                busy   = 1'b1;
                fu_Cin = carry_q;
                fu_BW  = bw_q;
                unique case (op_q)
                    OP_RRA: fu_FS = FS_RRA;
                    OP_RRC: fu_FS = FS_RRC;
                    OP_RLA: fu_FS = FS_ADD;
                    OP_RLC: fu_FS = FS_ADDC;
                    default: fu_FS = FS_NOP;
                endcase
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, step counter and held result; result/cvnz move only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_RRA;
            bw_q    <= 1'b0;
            steps_q <= '0;
            result  <= '0;
            cvnz    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= operand;
                        carry_q <= c_in;
                        op_q    <= op_e'(op);
                        bw_q    <= bw;
                        steps_q <= clamp_cnt(cnt);
                        if (cnt == '0) begin
                            result <= operand;
                            cvnz   <= {c_in, 1'b0, zero_msb, (operand == '0)};
                        end
                    end
                end
                ST_RUN: begin
                    if (!abort_hit) begin
                        acc_q   <= fu_F;
                        carry_q <= fu_CVNZ[3];
                        steps_q <= steps_q - CNT_W'(1);
                        if (last_step) begin
                            result <= fu_F;
                            cvnz   <= fu_CVNZ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_func_seq.sv
// Self-checking bench for func_seq: behavioural function unit plus closed-form shift/rotate reference.
module tb_func_seq;
    import func_seq_pkg::*;

    localparam int unsigned SIZE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [4:0]      cnt;
    logic            bw;
    logic [SIZE-1:0] operand;
    logic            c_in;
`ifdef FUNC_SEQ_ABORT_EN
    logic            abort;
`endif
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    logic [3:0]      cvnz;
    logic [SIZE-1:0] fu_A;
    logic [SIZE-1:0] fu_B;
    logic [5:0]      fu_FS;
    logic            fu_Cin;
    logic            fu_BW;
    logic [SIZE-1:0] fu_F;
    logic [3:0]      fu_CVNZ;

    int n_checks = 0;
    int n_err    = 0;
    logic [SIZE-1:0] last_res  = '0;
    logic [3:0]      last_cvnz = '0;

    always #5 clk = ~clk;

    func_seq #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cnt(cnt), .bw(bw),
        .operand(operand), .c_in(c_in),
`ifdef FUNC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .result(result), .cvnz(cvnz),
        .fu_A(fu_A), .fu_B(fu_B), .fu_FS(fu_FS), .fu_Cin(fu_Cin), .fu_BW(fu_BW),
        .fu_F(fu_F), .fu_CVNZ(fu_CVNZ)
    );

    // Behavioural function unit: adder and single-bit right shifter, byte mode on low half.
    function automatic logic [SIZE+3:0] fu_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                                 input logic [5:0] fs, input logic cin, input logic bm);
        int w, mask, ua, ub, s, f;
        logic c, v, nf, z;
        w = bm ? 8 : 16;
        mask = (1 << w) - 1;
        ua = int'(a) & mask;
        ub = int'(b) & mask;
        c = 1'b0;
        v = 1'b0;
        if (fs == FS_ADD || fs == FS_ADDC) begin
            s = ua + ub + ((fs == FS_ADDC) ? int'(cin) : 0);
            f = s & mask;
            c = ((s >> w) & 1) != 0;
            v = (((ua >> (w-1)) & 1) == ((ub >> (w-1)) & 1)) && (((f >> (w-1)) & 1) != ((ua >> (w-1)) & 1));
        end else if (fs == FS_RRA) begin
            f = (ub >> 1) | (ub & (1 << (w-1)));
            c = (ub & 1) != 0;
        end else if (fs == FS_RRC) begin
            f = (ub >> 1) | (int'(cin) << (w-1));
            c = (ub & 1) != 0;
        end else begin
            return {4'b0000, a};
        end
        nf = ((f >> (w-1)) & 1) != 0;
        z  = (f == 0);
        return {c, v, nf, z, SIZE'(f)};
    endfunction

    always_comb {fu_CVNZ, fu_F} = fu_model(fu_A, fu_B, fu_FS, fu_Cin, fu_BW);

    function automatic int rotr(input int v, input int r, input int len);
        if (r == 0) return v;
        return ((v >> r) | (v << (len - r))) & ((1 << len) - 1);
    endfunction

    // Closed-form result of n repeated steps.
    task automatic ref_model(input logic [1:0] o, input int n, input logic b, input logic [15:0] x,
                             input logic ci, output logic [15:0] res, output logic [3:0] fl);
        int w, mask, xm, sx, r, prev, rot, len, v;
        logic c, vf;
        w = b ? 8 : 16;
        mask = (1 << w) - 1;
        xm = int'(x) & mask;
        len = w + 1;
        vf = 1'b0;
        if (n == 0) begin
            res = x;
            fl  = {ci, 1'b0, (b ? x[7] : x[15]), (x == 16'd0)};
            return;
        end
        case (o)
            2'b00: begin
                sx = xm;
                if (((xm >> (w-1)) & 1) != 0) sx = xm - (1 << w);
                r = (sx >>> n) & mask;
                c = ((sx >>> (n-1)) & 1) != 0;
            end
            2'b10: begin
                r = (xm << n) & mask;
                prev = (xm << (n-1)) & mask;
                c = ((prev >> (w-1)) & 1) != 0;
                vf = (((prev >> (w-1)) ^ (prev >> (w-2))) & 1) != 0;
            end
            default: begin
                v = (int'(ci) << w) | xm;
                if (o == 2'b01) begin
                    rot = rotr(v, n % len, len);
                end else begin
                    rot = rotr(v, (len - (n % len)) % len, len);
                    prev = rotr(v, (len - ((n-1) % len)) % len, len) & mask;
                    vf = (((prev >> (w-1)) ^ (prev >> (w-2))) & 1) != 0;
                end
                r = rot & mask;
                c = ((rot >> w) & 1) != 0;
            end
        endcase
        res = 16'(r);
        fl  = {c, vf, (((r >> (w-1)) & 1) != 0), (r == 0)};
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":busy"},   32'(busy),   32'd0);
        check({tag, ":done"},   32'(done),   32'd0);
        check({tag, ":result"}, 32'(result), 32'd0);
        check({tag, ":cvnz"},   32'(cvnz),   32'd0);
        check({tag, ":fs"},     32'(fu_FS),  32'(FS_NOP));
        check({tag, ":fu_a"},   32'(fu_A),   32'd0);
        check({tag, ":cin_bw"}, 32'({fu_Cin, fu_BW}), 32'd0);
    endtask

    // disturb: 0 none, 1 restart mid-RUN, 2 reset, 3 abort; applied at RUN cycle at_k.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [4:0] n, input logic b,
                         input logic [15:0] x, input logic ci, input int disturb, input int at_k);
        logic [15:0] e_res;
        logic [3:0]  e_fl;
        int nc, lat, done_k;
        logic fs_moved;
        nc = (n > 5'd16) ? 16 : int'(n);
        ref_model(o, nc, b, x, ci, e_res, e_fl);
        lat = nc + 1;
        done_k = -1;
        fs_moved = 1'b0;
        op = o; cnt = n; bw = b; operand = x; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; operand = 16'($urandom); c_in = 1'($urandom); cnt = 5'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fu_FS != FS_NOP) fs_moved = 1'b1;
            if (k == 1) check({tag, ":busy"}, 32'(busy), 32'd1);
            if (done) begin
                done_k = k;
                break;
            end
            if (disturb != 0 && k == at_k) begin
                if (disturb == 1) begin
                    start = 1'b1; operand = ~x; cnt = 5'd3; op = ~o;
                    @(posedge clk); #1 start = 1'b0;
                end else if (disturb == 2) begin
                    rst = 1'b1;
                    @(posedge clk); #1 rst = 1'b0;
                    @(negedge clk);
                    check_reset_vals({tag, ":rst"});
                    last_res = '0;
                    last_cvnz = '0;
                    return;
                end
`ifdef FUNC_SEQ_ABORT_EN
                else if (disturb == 3) begin
                    abort = 1'b1;
                    @(posedge clk); #1 abort = 1'b0;
                    @(negedge clk);
                    check({tag, ":ab_busy"}, 32'(busy), 32'd0);
                    check({tag, ":ab_done"}, 32'(done), 32'd0);
                    check({tag, ":ab_res"},  32'(result), 32'(last_res));
                    check({tag, ":ab_cvnz"}, 32'(cvnz), 32'(last_cvnz));
                    fs_moved = 1'b0;
                    repeat (6) begin
                        @(negedge clk);
                        if (done) fs_moved = 1'b1;
                    end
                    check({tag, ":ab_nodone"}, 32'(fs_moved), 32'd0);
                    return;
                end
`endif
            end
        end
        check({tag, ":latency"}, 32'(done_k), 32'(lat));
        check({tag, ":result"},  32'(result), 32'(e_res));
        check({tag, ":cvnz"},    32'(cvnz),   32'(e_fl));
        if (n == 5'd0) check({tag, ":fs_nop"}, 32'(fs_moved), 32'd0);
        last_res = e_res;
        last_cvnz = e_fl;
        @(negedge clk);
        check({tag, ":pulse"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; cnt = '0; bw = 1'b0; operand = '0; c_in = 1'b0;
`ifdef FUNC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        do_op("rra_w3",   2'b00, 5'd3,  1'b0, 16'h8001, 1'b0, 0, 0);
        check("rra_w3:lit", 32'({result, cvnz}), 32'({16'hF000, 4'b0010}));
        do_op("rla_b1",   2'b10, 5'd1,  1'b1, 16'h0081, 1'b0, 0, 0);
        check("rla_b1:lit", 32'({result[7:0], cvnz[3], cvnz[1]}), 32'({8'h02, 1'b1, 1'b0}));
        do_op("rlc_w16",  2'b11, 5'd16, 1'b0, 16'h0000, 1'b1, 0, 0);
        check("rlc_w16:lit", 32'({result, cvnz[3], cvnz[1]}), 32'({16'h8000, 1'b0, 1'b1}));
        do_op("cnt0",     2'b01, 5'd0,  1'b0, 16'h0000, 1'b1, 0, 0);
        check("cnt0:lit", 32'({result, cvnz}), 32'({16'h0000, 4'b1001}));
        do_op("clamp",    2'b01, 5'd29, 1'b1, 16'h00A5, 1'b1, 0, 0);
        do_op("restart",  2'b00, 5'd6,  1'b0, 16'h1234, 1'b0, 1, 2);
        do_op("rst_run",  2'b11, 5'd5,  1'b0, 16'h4321, 1'b1, 2, 2);
        do_op("after_rst", 2'b01, 5'd4, 1'b0, 16'h0F0F, 1'b1, 0, 0);
`ifdef FUNC_SEQ_ABORT_EN
        do_op("pre_abort", 2'b10, 5'd2, 1'b0, 16'h00F0, 1'b0, 0, 0);
        do_op("abort",     2'b00, 5'd5, 1'b0, 16'h8888, 1'b1, 3, 2);
`endif
        for (int i = 0; i < 30; i++) begin
            do_op("rand", 2'($urandom), 5'($urandom_range(0, 31)), 1'($urandom),
                  16'($urandom), 1'($urandom), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/func_seq.md
# func_seq

Multi-step sequencer that drives the shared function unit (ALU + shifter) to perform repeated single-bit shift/rotate operations (RRA, RRC, RLA, RLC) by a count of 0–16 without CPU intervention. It sits between the execute-stage control logic and the function unit's operand/select inputs. Each cycle it feeds the previous result back as the operand and carries the C flag forward. It reports the final result and flags with a one-cycle done pulse.

## Interface
- SIZE, 16, datapath width; byte mode uses the low SIZE/2 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 RRA, 01 RRC, 10 RLA, 11 RLC.
- cnt  in  5  step count 0–16; values 17–31 are clamped to 16.
- bw  in  1  byte/word select, held for the whole operation.
- operand  in  SIZE  initial value.
- c_in  in  1  initial carry, taken from SR.C.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and cvnz are valid.
- result  out  SIZE  final value, held until the next accepted start.
- cvnz  out  4  {C,V,N,Z} of the final step, held like result.
- fu_A, fu_B  out  SIZE  function-unit operands.
- fu_FS  out  6  function select.
- fu_Cin  out  1  function-unit carry in.
- fu_BW  out  1  function-unit byte/word.
- fu_F  in  SIZE  function-unit output.
- fu_CVNZ  in  4  function-unit flags.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, cnt≠0:
  - latch operand→acc, c_in→carry, op, bw, clamped cnt→steps.
  - go to RUN.
- IDLE, start=1, cnt=0:
  - acc=operand; cvnz={c_in,0,msb(operand),operand==0}, where msb is bit SIZE/2-1 when bw=1, else bit SIZE-1.
  - go to DONE.
- RUN: drive the function unit combinationally from registered state:
  - RRA/RRC: fu_FS = FS_RRA/FS_RRC (shifter path); fu_B = acc; fu_A = acc.
  - RLA: fu_FS = FS_ADD; fu_A = fu_B = acc.
  - RLC: fu_FS = FS_ADDC; fu_A = fu_B = acc.
  - fu_Cin = carry; fu_BW = latched bw.
  - At the clock edge: acc←fu_F, carry←fu_CVNZ[3], flags←fu_CVNZ, steps←steps-1.
  - steps==1 at the edge → DONE.
- DONE: done=1 for exactly one cycle; result=acc, cvnz=flags. Go to IDLE.
- Outside RUN: fu_FS = FS_NOP, the function unit's pass-through code; fu_A/fu_B = acc; fu_Cin = 0; fu_BW = 0.
- start while busy: ignored, not queued.
- Byte mode: result is whatever the function unit produces. The sequencer does no masking.

## Timing
- Start accepted on edge T, cnt=n≥1:
  - RUN during cycles T+1 … T+n, one function-unit step per cycle.
  - done high in cycle T+n+1.
  - busy low again at T+n+2.
- cnt=0: done high in cycle T+1.
- Reset values: state=IDLE, busy=0, done=0, result=0, cvnz=0, acc=0, carry=0, steps=0; fu_* at IDLE values.
- rst during RUN or DONE: next cycle is IDLE with reset values. No done pulse is produced.
- result and cvnz change only on the edge entering DONE.
- Back-to-back: start may be asserted in the cycle after done, i.e. the first IDLE cycle.

## Configuration
- FUNC_SEQ_ABORT_EN defined:
  - adds input port `abort` (1 bit).
  - abort=1 in RUN: next cycle IDLE, no done pulse, result/cvnz keep their previous values, acc is discarded.
  - abort has priority over the steps==1 transition; it is ignored in IDLE and DONE.
- FUNC_SEQ_ABORT_EN undefined: no `abort` port; RUN always completes.

## Structure
- Shared package func_seq_pkg holds:
  - op encodings: OP_RRA, OP_RRC, OP_RLA, OP_RLC.
  - state encoding: ST_IDLE, ST_RUN, ST_DONE.
  - function-select constants: FS_RRA, FS_RRC, FS_ADD, FS_ADDC, FS_NOP, matching the function-unit decode table.
- No sub-module. The function unit is instantiated by the parent and connected through the fu_* ports; func_seq contains only the FSM, counter and accumulator.

## Test plan
- RRA, word, operand=0x8001, c_in=0, cnt=3 → result=0xF000, cvnz C=0 N=1 Z=0; done exactly 4 cycles after the start edge.
- RLA, byte, operand=0x0081, cnt=1 → result low byte 0x02, C=1, N=0; done at T+2.
- RLC, word, operand=0x0000, c_in=1, cnt=16 → result=0x8000, C=0, N=1; done at T+17.
- cnt=0, operand=0x0000, c_in=1 → done at T+1, result=0x0000, cvnz=4'b1001; fu_FS stays FS_NOP throughout.
- start pulsed again mid-RUN with different operand/cnt → ignored; the first operation's result and timing are unchanged.
- rst asserted in the 2nd RUN cycle → no done; all outputs at reset values next cycle; a new start is accepted the cycle after rst deasserts.
- With FUNC_SEQ_ABORT_EN: abort in the 2nd RUN cycle of a cnt=5 RRA → no done, result/cvnz retain the prior operation's values, FSM in IDLE next cycle.
